change_dispenser: RTL
=====================

# change_dispenser

Payout engine on the far side of the vending machine's money path: the machine accepts coin codes and computes the change owed; this block pays it out. It takes the 8-bit change amount, breaks it greedily into 10/5/2/1 coins from on-board inventory, and issues one coin code at a time to the coin hopper with a valid/ack handshake. It reports completion, amount paid, inventory shortfall and hopper jam.

## Interface
- INIT_N10, default 8: 10-unit coin count loaded at reset/refill (8-bit).
- INIT_N5, default 8: 5-unit coin count loaded at reset/refill.
- INIT_N2, default 8: 2-unit coin count loaded at reset/refill.
- INIT_N1, default 8: 1-unit coin count loaded at reset/refill.
- ACK_TIMEOUT, default 16: ISSUE cycles without ack before jam abort; legal range 1..255.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req  in  1  start payout; sampled only in IDLE.
- amount  in  8  change to pay, latched with req.
- refill  in  1  reload all counts to INIT_*; honoured only in IDLE.
- coin_ack  in  1  hopper accepted current coin; meaningful only while coin_valid.
- coin_valid  out  1  coin_code is presented.
- coin_code  out  3  1=1-unit, 2=2-unit, 3=5-unit, 4=10-unit, 0 when not valid.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- paid  out  8  units paid in current/last payout.
- short_err  out  1  last payout ended with unpaid remainder; held until next req.
- jam_err  out  1  last payout aborted on ack timeout; held until next req.

## Operation
- States: IDLE, SELECT, ISSUE, FINISH. Moore outputs: coin_valid = ISSUE, done = FINISH, busy = not IDLE.
- IDLE: req=1 -> latch remaining=amount, paid=0, clear short_err/jam_err, go SELECT. refill=1 (req=0) -> reload counts, stay IDLE. req and refill together: req wins, refill dropped.
- SELECT: pick largest denomination d with d <= remaining and count(d) > 0. remaining==0 -> FINISH. No d and remaining>0 -> set short_err, FINISH. Else register coin_code, clear timeout counter, go ISSUE.
- ISSUE: coin_ack=1 -> remaining -= d, paid += d, count(d) -= 1, go SELECT. Else timeout counter +1; when it reaches ACK_TIMEOUT -> set jam_err, FINISH; no decrement for the un-acked coin.
- FINISH: one cycle, then IDLE.
- Arithmetic: all 8-bit unsigned; greedy guard (d <= remaining, count > 0) makes underflow impossible; paid never exceeds amount.
- req, refill, amount ignored while busy. coin_ack ignored outside ISSUE.
- reset: state IDLE, remaining=0, paid=0, short_err=0, jam_err=0, coin_code=0, timeout=0, counts reloaded to INIT_*. Reset mid-payout abandons it silently (no done pulse).

## Timing
- req high cycle 0 -> SELECT cycle 1 -> first coin_valid cycle 2.
- coin_ack in cycle k (ISSUE) -> coin_valid low k+1 (SELECT) -> next coin_valid k+2, or done high k+2 if finished.
- Minimum 2 cycles per coin; coin_code stable throughout ISSUE.
- amount=0: done high cycle 2, busy low cycle 3, paid=0, no errors.
- Jam: coin_valid high ACK_TIMEOUT cycles, FINISH the next cycle.
- All outputs registered or decoded from registered state; no combinational input-to-output path.

## Structure
- Shared package vm_pkg: coin code constants, denomination values (10,5,2,1), code<->value mapping, state encoding.
- Sub-module coin_selector: combinational greedy picker (remaining + four counts -> found, coin_code, value); instantiated once, reusable by datapath for exact-change checking.
- change_dispenser holds FSM, remaining/paid, four inventory counters, timeout counter.

## Test plan
- Default inventory, amount=18, ack same cycle as each valid -> codes 4,3,2,1; paid=18; done; no errors; counts 7,7,7,7.
- refill after N5 drained to 0 via prior payouts of 5; amount=7 before refill -> codes 2,2,2,1, paid=7; after refill, amount=7 -> codes 3,2.
- INIT_N2=0, INIT_N1=0, amount=3 -> no coin_valid, done cycle 2, short_err=1, paid=0.
- amount=12, ack withheld on second coin -> code 4 paid, code 2 valid 16 cycles, jam_err=1, paid=10, N2 unchanged.
- amount=0 -> done cycle 2, busy low cycle 3; req held during busy ignored.
- reset asserted in ISSUE -> next cycle busy=0, coin_valid=0, paid=0, counts back to INIT_*, no done pulse.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin codes, denomination values,
// code/value mapping and the payout FSM state encoding.
package vm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [2:0] CODE_NONE = 3'd0;
  localparam logic [2:0] CODE_1    = 3'd1;
  localparam logic [2:0] CODE_2    = 3'd2;
  localparam logic [2:0] CODE_5    = 3'd3;
  localparam logic [2:0] CODE_10   = 3'd4;

  localparam logic [7:0] VAL_1  = 8'd1;
  localparam logic [7:0] VAL_2  = 8'd2;
  localparam logic [7:0] VAL_5  = 8'd5;
  localparam logic [7:0] VAL_10 = 8'd10;

  // Observability bundle: FSM state plus the four inventory counters.
  typedef struct packed {
    state_t     state;
    logic [7:0] n10;
    logic [7:0] n5;
    logic [7:0] n2;
    logic [7:0] n1;
  } dbg_t;

  function automatic logic [7:0] code_to_value(input logic [2:0] code);
    case (code)
      CODE_1:  return VAL_1;
      CODE_2:  return VAL_2;
      CODE_5:  return VAL_5;
      CODE_10: return VAL_10;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [2:0] value_to_code(input logic [7:0] value);
    case (value)
      VAL_1:   return CODE_1;
      VAL_2:   return CODE_2;
      VAL_5:   return CODE_5;
      VAL_10:  return CODE_10;
      default: return CODE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Bus between the money path / coin hopper (master) and the change dispenser
// (slave).
//
// Handshakes: req is a single-cycle-or-longer start strobe, sampled only while
// the dispenser is idle (busy=0), with amount latched in that same cycle.
// coin_valid/coin_ack is a valid/ready pair: coin_code is held stable while
// coin_valid is high, and the coin is transferred on the rising clock edge at
// which both coin_valid and coin_ack are high. coin_ack without coin_valid has
// no effect. done is a one-cycle pulse after the last coin (or an abort).
interface change_dispenser_if;
  import vm_pkg::*;

  logic       req;
  logic [7:0] amount;
  logic       refill;
  logic       coin_ack;
  logic       coin_valid;
  logic [2:0] coin_code;
  logic       busy;
  logic       done;
  logic [7:0] paid;
  logic       short_err;
  logic       jam_err;
  dbg_t       dbg;

  modport master (
    output req, amount, refill, coin_ack,
    input  coin_valid, coin_code, busy, done, paid, short_err, jam_err, dbg
  );

  modport slave (
    input  req, amount, refill, coin_ack,
    output coin_valid, coin_code, busy, done, paid, short_err, jam_err, dbg
  );

endinterface

// File: rtl/coin_selector.sv
// Greedy coin picker: largest denomination not exceeding the remaining amount
// for which inventory is left. Purely combinational.
module coin_selector
  import vm_pkg::*;
(
  input  logic [7:0] remaining,
  input  logic [7:0] n10,
  input  logic [7:0] n5,
  input  logic [7:0] n2,
  input  logic [7:0] n1,
  output logic       found,
  output logic [2:0] code,
  output logic [7:0] value
);

  // Priority walk from the largest denomination down.
  always_comb begin
    found = 1'b0;
    value = 8'd0;
    if (remaining >= VAL_10 && n10 != 8'd0) begin
      found = 1'b1;
      value = VAL_10;
    end else if (remaining >= VAL_5 && n5 != 8'd0) begin
      found = 1'b1;
      value = VAL_5;
    end else if (remaining >= VAL_2 && n2 != 8'd0) begin
      found = 1'b1;
      value = VAL_2;
    end else if (remaining >= VAL_1 && n1 != 8'd0) begin
      found = 1'b1;
      value = VAL_1;
    end
    code = value_to_code(value);
  end

endmodule

// File: rtl/change_dispenser.sv
// Change payout engine: breaks an amount into 10/5/2/1 coins from inventory
// and hands them to the hopper one at a time, with shortfall and jam reporting.
module change_dispenser
  import vm_pkg::*;
#(
  parameter logic [7:0] INIT_N10    = 8'd8,
  parameter logic [7:0] INIT_N5     = 8'd8,
  parameter logic [7:0] INIT_N2     = 8'd8,
  parameter logic [7:0] INIT_N1     = 8'd8,
  parameter logic [7:0] ACK_TIMEOUT = 8'd16
) (
  input logic               clk,
  input logic               reset,
  change_dispenser_if.slave bus
);

  state_t     state, state_next;
  logic [7:0] remaining_q, paid_q;
  logic [7:0] n10_q, n5_q, n2_q, n1_q;
  logic [2:0] code_q;
  logic [7:0] coin_val_q;
  logic [7:0] tmo_q;
  logic [7:0] tmo_inc;
  logic       short_q, jam_q;
  logic       sel_found;
  logic [2:0] sel_code;
  logic [7:0] sel_value;

  assign tmo_inc = tmo_q + 8'd1;

  coin_selector u_sel (
    .remaining (remaining_q),
    .n10       (n10_q),
    .n5        (n5_q),
    .n2        (n2_q),
    .n1        (n1_q),
    .found     (sel_found),
    .code      (sel_code),
    .value     (sel_value)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (bus.req) state_next = ST_SELECT;
      ST_SELECT: begin
        if (remaining_q == 8'd0 || !sel_found) state_next = ST_FINISH;
        else                                   state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (bus.coin_ack)                state_next = ST_SELECT;
        else if (tmo_inc == ACK_TIMEOUT) state_next = ST_FINISH;
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Datapath: amount tracking, inventory, timeout and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining_q <= 8'd0;
      paid_q      <= 8'd0;
      short_q     <= 1'b0;
      jam_q       <= 1'b0;
      code_q      <= CODE_NONE;
      coin_val_q  <= 8'd0;
      tmo_q       <= 8'd0;
      n10_q       <= INIT_N10;
      n5_q        <= INIT_N5;
      n2_q        <= INIT_N2;
      n1_q        <= INIT_N1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            remaining_q <= bus.amount;
            paid_q      <= 8'd0;
            short_q     <= 1'b0;
            jam_q       <= 1'b0;
          end else if (bus.refill) begin
            n10_q <= INIT_N10;
            n5_q  <= INIT_N5;
            n2_q  <= INIT_N2;
            n1_q  <= INIT_N1;
          end
        end
        ST_SELECT: begin
          if (remaining_q != 8'd0) begin
            if (sel_found) begin
              code_q     <= sel_code;
              coin_val_q <= sel_value;
              tmo_q      <= 8'd0;
            end else begin
              short_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (bus.coin_ack) begin
            // Guarded by the selector, so neither subtraction can wrap.
            remaining_q <= remaining_q - coin_val_q;
            paid_q      <= paid_q + coin_val_q;
            case (code_q)
              CODE_10: n10_q <= n10_q - 8'd1;
              CODE_5:  n5_q  <= n5_q - 8'd1;
              CODE_2:  n2_q  <= n2_q - 8'd1;
              CODE_1:  n1_q  <= n1_q - 8'd1;
              default: ;
            endcase
          end else begin
            tmo_q <= tmo_inc;
            if (tmo_inc == ACK_TIMEOUT) jam_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    bus.coin_valid = (state == ST_ISSUE);
    bus.coin_code  = (state == ST_ISSUE) ? code_q : CODE_NONE;
    bus.done       = (state == ST_FINISH);
    bus.busy       = (state != ST_IDLE);
    bus.paid       = paid_q;
    bus.short_err  = short_q;
    bus.jam_err    = jam_q;
    bus.dbg        = '{state: state, n10: n10_q, n5: n5_q, n2: n2_q, n1: n1_q};
  end

endmodule
